// File: rtl/card_pkg.sv
// Shared constants, state encoding and draw-mask helper for the card shuffler.
package card_pkg;

    localparam int unsigned N_CARDS = 16;
    localparam int unsigned CARD_W  = 4;
    localparam int unsigned LFSR_W  = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned FLAT_W  = N_CARDS * CARD_W;

    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [FLAT_W-1:0] IDENTITY     = 64'hFEDCBA9876543210;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INIT    = 2'd1,
        SHUFFLE = 2'd2,
        DONE    = 2'd3
    } shuf_state_t;

    // Smallest all-ones value that covers index i, so the masked draw spans 0..mask.
    function automatic logic [IDX_W-1:0] draw_mask(input logic [IDX_W-1:0] i);
        if (i >= 4'd8)      return 4'd15;
        else if (i >= 4'd4) return 4'd7;
        else if (i >= 4'd2) return 4'd3;
        else                return 4'd1;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// 16-bit Galois LFSR (right-shifting) with synchronous active-low reset and parallel load.
module card_lfsr
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q
);

    // Load wins over the free-running advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= SEED;
        end else if (load) begin
            q <= load_val;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/card_shuffler.sv
// Fisher-Yates style 16-card shuffler driven by a free-running LFSR.
// Optional macro CARD_SHUFFLER_SEED_IN_EN adds a seed input loaded on start acceptance.
module card_shuffler
    import card_pkg::*;
#(
    parameter logic [15:0] LFSR_RESET_SEED = DEFAULT_SEED,
    parameter int unsigned MAX_REJECT      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [63:0] pos_flat,
    output logic        valid,
    output logic        busy,
    output logic        done
`ifdef CARD_SHUFFLER_SEED_IN_EN
    ,
    input  logic [15:0] seed
`endif
);

    localparam int unsigned REJ_W = $clog2(MAX_REJECT + 1);

    shuf_state_t state, state_next;

    logic [IDX_W-1:0]  idx, idx_next;
    logic [REJ_W-1:0]  rej, rej_next;
    logic [FLAT_W-1:0] pos_next;
    logic              valid_next;
    logic              busy_next;
    logic              done_next;

    logic [15:0]       lfsr_q;
    logic [11:0]       lfsr_hi_unused;
    logic [3:0]        lfsr_nib;
    logic              lfsr_load;
    logic [15:0]       lfsr_load_val;

    logic [IDX_W-1:0]  mask;
    logic [IDX_W-1:0]  j_raw;
    logic [IDX_W-1:0]  j;
    logic              force_draw;
    logic              accept;

    // Only the low nibble feeds the draw.
    assign {lfsr_hi_unused, lfsr_nib} = lfsr_q;

`ifdef CARD_SHUFFLER_SEED_IN_EN
    assign lfsr_load     = (state == IDLE) && start;
    assign lfsr_load_val = (seed == 16'h0000) ? LFSR_RESET_SEED : seed;
`else
    assign lfsr_load     = 1'b0;
    assign lfsr_load_val = LFSR_RESET_SEED;
`endif

    card_lfsr #(
        .SEED     (LFSR_RESET_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .q        (lfsr_q)
    );

    // Draw stage: masked LFSR pick, halved and force-accepted after too many rejects.
    always_comb begin
        mask       = draw_mask(idx);
        j_raw      = lfsr_nib & mask;
        force_draw = (rej == REJ_W'(MAX_REJECT));
        j          = force_draw ? (j_raw >> 1) : j_raw;
        accept     = force_draw || (j <= idx);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next = state;
        pos_next   = pos_flat;
        idx_next   = idx;
        rej_next   = rej;
        valid_next = valid;
        busy_next  = busy;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = INIT;
                    busy_next  = 1'b1;
                end
            end
            INIT: begin
                pos_next   = IDENTITY;
                valid_next = 1'b0;
                idx_next   = 4'd15;
                rej_next   = '0;
                state_next = SHUFFLE;
            end
            SHUFFLE: begin
                if (accept) begin
                    pos_next[{idx, 2'b00} +: CARD_W] = pos_flat[{j, 2'b00} +: CARD_W];
                    pos_next[{j, 2'b00} +: CARD_W]   = pos_flat[{idx, 2'b00} +: CARD_W];
                    idx_next = idx - 4'd1;
                    rej_next = '0;
                    if (idx == 4'd1) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        valid_next = 1'b1;
                        busy_next  = 1'b0;
                    end
                end else begin
                    rej_next = rej + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            pos_flat <= IDENTITY;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            idx      <= 4'd15;
            rej      <= '0;
        end else begin
            state    <= state_next;
            pos_flat <= pos_next;
            valid    <= valid_next;
            busy     <= busy_next;
            done     <= done_next;
            idx      <= idx_next;
            rej      <= rej_next;
        end
    end

endmodule

// File: tb/tb_card_shuffler.sv
// Directed self-checking bench for card_shuffler with a behavioural shuffle reference.
module tb_card_shuffler;

    localparam logic [63:0] ID_PERM = 64'hFEDCBA9876543210;
    localparam logic [15:0] SEED0   = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] pos_flat;
    logic        valid;
    logic        busy;
    logic        done;
`ifdef CARD_SHUFFLER_SEED_IN_EN
    logic [15:0] seed_v = 16'h0000;
`endif

    int tests = 0;
    int fails = 0;

    logic [15:0] m_lfsr;

    card_shuffler dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pos_flat (pos_flat),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
`ifdef CARD_SHUFFLER_SEED_IN_EN
        ,
        .seed     (seed_v)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] q);
        return (q >> 1) ^ (q[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Free-running reference of the LFSR (default build: no reloads).
    always @(posedge clk) begin
        if (!rst) m_lfsr <= SEED0;
        else      m_lfsr <= step(m_lfsr);
    end

    function automatic int mask_of(input int i);
        if (i > 7)      return 15;
        else if (i > 3) return 7;
        else if (i > 1) return 3;
        else            return 1;
    endfunction

    // Reference shuffle: first_q is the LFSR value seen by the first draw.
    // From draw number force_at on, the draw sees 16'h0003; stops after stop_at draws.
    function automatic void model_run(input logic [15:0] first_q, input int force_at,
                                      input int stop_at, output logic [63:0] perm,
                                      output int draws, output int d7, output int d2);
        logic [3:0]  slot [16];
        logic [3:0]  tmp;
        logic [15:0] q;
        logic [15:0] qu;
        int i, rej, n, j, raw;
        logic acc;
        for (int k = 0; k < 16; k++) slot[k] = 4'(k);
        q = first_q; i = 15; rej = 0; n = 0; d7 = -1; d2 = -1;
        while (i >= 1 && n != stop_at) begin
            if (i == 7 && d7 < 0) d7 = n;
            if (i == 2 && d2 < 0) d2 = n;
            qu  = (n >= force_at) ? 16'h0003 : q;
            raw = int'(qu[3:0]) & mask_of(i);
            if (rej == 8) begin
                j = raw / 2; acc = 1'b1;
            end else begin
                j = raw; acc = (raw <= i);
            end
            if (acc) begin
                tmp = slot[i]; slot[i] = slot[j]; slot[j] = tmp;
                i = i - 1; rej = 0;
            end else begin
                rej = rej + 1;
            end
            q = step(q);
            n = n + 1;
        end
        perm = '0;
        for (int k = 0; k < 16; k++) perm[4*k +: 4] = slot[k];
        draws = n;
    endfunction

    function automatic logic is_perm(input logic [63:0] p);
        logic [15:0] seen;
        seen = '0;
        for (int k = 0; k < 16; k++) seen[p[4*k +: 4]] = 1'b1;
        return seen == 16'hFFFF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    // LFSR value the first draw will see if start is accepted at the coming edge.
    task automatic get_first_q(output logic [15:0] fq);
`ifdef CARD_SHUFFLER_SEED_IN_EN
        fq = step((seed_v == 16'h0000) ? SEED0 : seed_v);
`else
        fq = step(step(m_lfsr));
`endif
    endtask

    task automatic start_accept(output logic [15:0] fq);
        get_first_q(fq);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            tick();
            cyc++;
            if (done) break;
        end
    endtask

`ifdef CARD_SHUFFLER_SEED_IN_EN
    task automatic run_seeded(input logic [15:0] s, input string tag);
        logic [15:0] fq;
        logic [63:0] ex;
        int dr, a7, a2, c;
        seed_v = s;
        do_reset();
        repeat (3) tick();
        start_accept(fq);
        model_run(fq, 1000, 1000, ex, dr, a7, a2);
        wait_done(150, c);
        check({tag, "_lat"}, 64'(c), 64'(dr + 1));
        check({tag, "_perm"}, pos_flat, ex);
    endtask
`endif

    initial begin
        logic [15:0] fq, fq2;
        logic [63:0] ex, ex2, exa, exb;
        int dr, dr2, d7, d2, c, npulse, t7, t2;

        // Reset values
        do_reset();
        check("rst_pos", pos_flat, ID_PERM);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        // Single start five cycles after reset release
        repeat (5) tick();
        start_accept(fq);
        check("start_busy", 64'(busy), 64'd1);
        model_run(fq, 1000, 1000, ex, dr, d7, d2);
        wait_done(150, c);
        check("single_lat", 64'(c), 64'(dr + 1));
        check("single_lat_bound", 64'(c <= 137), 64'd1);
        check("single_perm", pos_flat, ex);
        check("single_is_perm", 64'(is_perm(pos_flat)), 64'd1);
        check("single_valid", 64'(valid), 64'd1);
        check("single_busy", 64'(busy), 64'd0);
        tick();
        check("done_one_cycle", 64'(done), 64'd0);
        repeat (3) tick();
        check("idle_hold_perm", pos_flat, ex);
        check("idle_hold_valid", 64'(valid), 64'd1);
        check("idle_hold_done", 64'(done), 64'd0);

        // Start held high through the whole shuffle and the DONE cycle
        do_reset();
        repeat (5) tick();
        get_first_q(fq);
        start = 1'b1;
        tick();
        check("held_busy", 64'(busy), 64'd1);
        model_run(fq, 1000, 1000, ex, dr, d7, d2);
        c = 0;
        while (c < 150) begin
            tick();
            c++;
            if (done) break;
        end
        check("held_lat", 64'(c), 64'(dr + 1));
        check("held_perm", pos_flat, ex);
        tick();
        check("done_start_ignored_busy", 64'(busy), 64'd0);
        check("done_start_ignored_done", 64'(done), 64'd0);
        check("done_start_ignored_valid", 64'(valid), 64'd1);
        get_first_q(fq2);
        tick();
        start = 1'b0;
        check("idle_start_accepted", 64'(busy), 64'd1);
        tick();
        check("init_valid_drop", 64'(valid), 64'd0);
        check("init_identity", pos_flat, ID_PERM);
        model_run(fq2, 1000, 1000, ex2, dr2, d7, d2);
        wait_done(150, c);
        check("restart_lat", 64'(c), 64'(dr2));
        check("restart_perm", pos_flat, ex2);

        // Eight forced rejects at i=2, then the halved draw is taken
        do_reset();
        repeat (5) tick();
        start_accept(fq);
        model_run(fq, 1000, 1000, ex, dr, t7, t2);
        model_run(fq, t2, 1000, ex, dr, d7, d2);
        model_run(fq, t2, t2 + 8, exa, dr2, d7, d2);
        model_run(fq, t2, t2 + 9, exb, dr2, d7, d2);
        repeat (1 + t2) tick();
        force dut.u_lfsr.q = 16'h0003;
        repeat (8) tick();
        check("reject8_no_swap", pos_flat, exa);
        check("reject8_busy", 64'(busy), 64'd1);
        tick();
        check("forced_swap", pos_flat, exb);
        tick();
        check("forced_done", 64'(done), 64'd1);
        check("forced_perm", pos_flat, ex);
        check("forced_is_perm", 64'(is_perm(pos_flat)), 64'd1);
        release dut.u_lfsr.q;

        // Reset asserted mid-shuffle while i=7
        do_reset();
        repeat (5) tick();
        start_accept(fq);
        model_run(fq, 1000, 1000, ex, dr, t7, t2);
        repeat (1 + t7) tick();
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_pos", pos_flat, ID_PERM);
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        npulse = 0;
        repeat (150) begin
            tick();
            if (done) npulse++;
        end
        check("abort_no_done", 64'(npulse), 64'd0);

`ifdef CARD_SHUFFLER_SEED_IN_EN
        // Seed input: zero falls back to the reset seed; same seed repeats
        run_seeded(16'h0000, "seed0");
        ex = pos_flat;
        run_seeded(SEED0, "seedace1");
        check("seed0_eq_ace1", pos_flat, ex);
        run_seeded(16'h1234, "seed1234_a");
        ex = pos_flat;
        run_seeded(16'h1234, "seed1234_b");
        check("seed1234_repeat", pos_flat, ex);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
